// File: rtl/times_table_pkg.sv
// Shared types and size helpers for the self-filling multiplication lookup table.
package times_table_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_t;

    function automatic int res_w(input int w);
        return 2 * w;
    endfunction

    function automatic int depth(input int w);
        return 1 << (2 * w);
    endfunction

endpackage

// File: rtl/param_bram.sv
// Generic single-port synchronous RAM with registered, read-first output.
module param_bram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/times_table_lut.sv
// WIDTH x WIDTH multiplication table in RAM: self-fills after reset or rebuild,
// then serves 1-cycle-latency lookups over a valid/ready handshake.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  INIT  | writing RAM[cnt] = hi(cnt) * lo(cnt), one entry per cycle
//  SERVE | table complete, lookups accepted with output backpressure
module times_table_lut
    import times_table_pkg::*;
#(
    parameter  int WIDTH = 3,
    localparam int RES_W = res_w(WIDTH),
    localparam int DEPTH = depth(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             init_done,
    input  logic             rebuild
);

    localparam int ADDR_W = 2 * WIDTH;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              accept;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [RES_W-1:0]  fill_prod;
    logic [RES_W-1:0]  ram_dout;

    // rebuild wins over a same-cycle request, so refuse it up front
    assign in_ready  = (state == SERVE) && !rebuild && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    assign fill_prod = RES_W'(cnt[ADDR_W-1:WIDTH]) * RES_W'(cnt[WIDTH-1:0]);
    assign ram_we    = (state == INIT);
    assign ram_en    = (state == INIT) || accept;
    assign ram_addr  = (state == INIT) ? cnt : {a, b};

    // RAM output holds while stalled because the read enable drops;
    // masking keeps result at zero whenever nothing valid is presented
    assign result    = ram_dout & {RES_W{out_valid}};

    param_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (RES_W)
    ) u_bram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (fill_prod),
        .dout (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == LAST) begin
                        state     <= SERVE;
                        init_done <= 1'b1;
                    end
                end
                SERVE: begin
                    if (rebuild) begin
                        state     <= INIT;
                        cnt       <= '0;
                        init_done <= 1'b0;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: doc/times_table_lut.md
Name: times_table_lut

Overview:
- Parametrised successor to the fixed 8x8 times-table block: a WIDTH x WIDTH-bit multiplication lookup table held in a single-port RAM.
- Fills its own table after reset, so no preloaded init file is needed. It can also rebuild the table on request.
- Serves lookups over a valid/ready handshake with 1-cycle latency and output backpressure.
- Sits between operand producers and downstream arithmetic logic wherever a cheap registered product is wanted.

Parameters:
- WIDTH, 3, operand width in bits for a and b (1..6). Derived, not overridable: RES_W = 2*WIDTH; DEPTH = 2**(2*WIDTH).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  lookup request valid
- in_ready  out  1  block can accept a request this cycle
- a  in  WIDTH  operand a (unsigned), address MSBs
- b  in  WIDTH  operand b (unsigned), address LSBs
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  RES_W  a*b, unsigned
- init_done  out  1  table filled, block in SERVE
- rebuild  in  1  pulse: refill table

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=0, out_valid=0, result=0, init_done=0, fill counter=0, state=INIT.
- The state machine has two states, INIT and SERVE.
- INIT:
  - Each cycle writes RAM[cnt] = cnt[2W-1:W] * cnt[W-1:0], zero-extended to RES_W, then increments cnt.
  - Lasts exactly DEPTH cycles.
  - In the cycle that writes cnt = DEPTH-1, the next state is SERVE, cnt wraps to 0 and init_done rises.
  - in_ready=0 and out_valid=0 throughout INIT. Inputs a, b and in_valid are ignored.
- SERVE:
  - in_ready = !out_valid || out_ready (combinational).
  - A request is accepted when in_valid && in_ready. The RAM reads address {a,b} with enable=1.
  - On the next edge, result = RAM[{a,b}] and out_valid=1. Latency is 1 cycle.
  - out_valid clears on out_ready when no new request is accepted in the same cycle.
  - When out_valid && !out_ready, the RAM enable is 0. result and out_valid hold stable, and a, b changes have no effect.
  - Simultaneous out_ready and accept: the new result replaces the old with no bubble. Sustained throughput is 1 lookup/cycle.
- rebuild:
  - Sampled only in SERVE; ignored in INIT.
  - In the next cycle: state=INIT, cnt=0, init_done=0, out_valid=0. Any unconsumed result is discarded.
  - rebuild takes priority over a same-cycle accept; that request is dropped and in_ready is 0 during that cycle.
- rst mid-INIT or mid-SERVE: returns to reset values next edge and restarts the fill from 0.
- Arithmetic: unsigned throughout. The maximum product (2^W-1)^2 fits in RES_W and cannot overflow.
- RAM write port is used only in INIT. The read and write address share the port, muxed by state.

Decomposition:
- Package times_table_pkg holds:
  - state enum {INIT, SERVE};
  - functions res_w(w) = 2*w and depth(w) = 1<<(2*w).
- Sub-module param_bram, a generic single-port synchronous RAM:
  - parameters ADDR_W and DATA_W;
  - ports clk, en, we, addr, din, dout;
  - registered read, read-first.
- The top block holds the state machine, the fill counter and the handshake logic.

Test Plan:
- WIDTH=3, release rst at cycle 0: in_ready=0 and init_done=0 for 64 cycles. init_done=1 and in_ready=1 on cycle 64 (not before).
- After init, accept a=7, b=6 with out_ready=1: the next cycle gives out_valid=1, result=42. Sweep all 64 pairs back-to-back: every result equals a*b with one result per cycle.
- Backpressure: request a=5, b=3, hold out_ready=0 for 4 cycles while changing a and b to 2 and 2. result stays 15, out_valid stays 1 and in_ready=0. Raise out_ready: 15 is consumed, then 2*2=4 is accepted.
- rebuild pulse with out_valid=1 pending and in_valid=1: the next cycle has out_valid=0 and init_done=0, and the request is dropped. init_done returns after 64 cycles and lookups are correct again.
- rst asserted at INIT cycle 30: the fill restarts and init_done rises exactly 64 cycles after rst is released.
- WIDTH=4: a=15, b=15 gives result=225 (8-bit), and init takes 256 cycles.
